// File: rtl/stopwatch_lap.sv
// Stopwatch core: debounced keys, run-gated tick divider, up/down mm:ss.cc BCD counter,
// lap buffer with recall, and active-low 7-segment decode of the displayed value.
module stopwatch_lap #(
    parameter int TICK_DIV  = 500000,
    parameter int DEBOUNCE  = 1000000,
    parameter int LAP_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_start_pause,
    input  logic        key_lap,
    input  logic        key_recall,
    input  logic        mode_down,
    input  logic        preset_load,
    input  logic [23:0] preset_bcd,
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        expired,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic        lap_full,
    output logic        recall_active,
    output logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] recall_idx,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam int CNT_W = $clog2(LAP_DEPTH + 1);
    localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LAP_DEPTH);

    // Digit order in the packed word: index 0 = cc_l ... index 5 = mm_h.
    function automatic logic [3:0] digit_max(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == digit_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        borrow;
        r      = t;
        borrow = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_valid(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[4*i +: 4] > digit_max(i)) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b100_0000;
            4'd1:    return 7'b111_1001;
            4'd2:    return 7'b010_0100;
            4'd3:    return 7'b011_0000;
            4'd4:    return 7'b001_1001;
            4'd5:    return 7'b001_0010;
            4'd6:    return 7'b000_0010;
            4'd7:    return 7'b111_1000;
            4'd8:    return 7'b000_0000;
            4'd9:    return 7'b001_0000;
            default: return 7'b111_1111;
        endcase
    endfunction

    logic [2:0]       key_raw;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [2:0]       key_level;
    logic [2:0]       press;
    logic [DB_W-1:0]  db_cnt [3];

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_n;
    logic             tick_n;
    logic             tick_p1;
    logic [23:0]      preset_q;
    logic [23:0]      preset_n;
    logic [23:0]      time_n;
    logic             run_n;
    logic             exp_n;
    logic             ract_n;
    logic             push;
    logic             load_ok;
    logic             clear;
    logic [CNT_W-1:0] cnt_n;
    logic [IDX_W-1:0] ridx_n;
    logic [23:0]      lap_mem [LAP_DEPTH];

    assign key_raw = {key_recall, key_lap, key_start_pause};

    // Key synchroniser + debounce: key_level flips only after DEBOUNCE consecutive
    // samples disagree with it; the press pulse is the high-to-low flip itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            key_level <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == key_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    key_level[i] <= sync_p1[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            press[i] = key_level[i] && !sync_p1[i] && (db_cnt[i] == DB_LAST);
        end
    end

    // Next-state: tick effect first, then preset/clear, start, lap, recall in
    // rising priority of override. Lap and start both look at the current running.
    always_comb begin
        run_n    = running;
        exp_n    = expired;
        time_n   = time_bcd;
        preset_n = preset_q;
        div_n    = div_q;
        tick_n   = 1'b0;
        cnt_n    = lap_count;
        ract_n   = recall_active;
        ridx_n   = recall_idx;
        push     = 1'b0;

        if (running) begin
            if (div_q == DIV_LAST) begin
                div_n  = '0;
                tick_n = 1'b1;
            end else begin
                div_n = div_q + DIV_W'(1);
            end
        end

        if (tick_p1) begin
            if (mode_down) begin
                if (time_bcd == 24'h000001 || time_bcd == 24'h000000) begin
                    time_n = '0;
                    run_n  = 1'b0;
                    exp_n  = 1'b1;
                end else begin
                    time_n = bcd_dec(time_bcd);
                end
            end else begin
                time_n = bcd_inc(time_bcd);
            end
        end

        load_ok = preset_load && !running && bcd_valid(preset_bcd);
        clear   = press[1] && !running;

        if (load_ok) begin
            time_n   = preset_bcd;
            preset_n = preset_bcd;
            exp_n    = 1'b0;
        end else if (clear) begin
            time_n = mode_down ? preset_q : 24'h000000;
            div_n  = '0;
        end

        if (press[0]) begin
            exp_n = 1'b0;
            if (running) begin
                run_n = 1'b0;
            end else if (!(mode_down && time_bcd == 24'h000000)) begin
                run_n = 1'b1;
            end
        end

        if (press[1]) begin
            if (running) begin
                if (lap_count != CNT_FULL) begin
                    push  = 1'b1;
                    cnt_n = lap_count + CNT_W'(1);
                end
            end else begin
                cnt_n  = '0;
                ract_n = 1'b0;
            end
        end

        if (press[2] && lap_count != '0 && !clear) begin
            if (!recall_active) begin
                ract_n = 1'b1;
                ridx_n = '0;
            end else if (CNT_W'(recall_idx) == lap_count - CNT_W'(1)) begin
                ract_n = 1'b0;
            end else begin
                ridx_n = recall_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running       <= 1'b0;
            expired       <= 1'b0;
            time_bcd      <= '0;
            preset_q      <= '0;
            div_q         <= '0;
            tick_p1       <= 1'b0;
            lap_count     <= '0;
            recall_active <= 1'b0;
            recall_idx    <= '0;
            disp_bcd      <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else begin
            running       <= run_n;
            expired       <= exp_n;
            time_bcd      <= time_n;
            preset_q      <= preset_n;
            div_q         <= div_n;
            tick_p1       <= tick_n;
            lap_count     <= cnt_n;
            recall_active <= ract_n;
            recall_idx    <= ridx_n;
            if (push) lap_mem[lap_count[IDX_W-1:0]] <= time_bcd;
            disp_bcd <= recall_active ? lap_mem[recall_idx] : time_bcd;
        end
    end

    assign lap_full = (lap_count == CNT_FULL);

    assign hex0 = seg7(disp_bcd[3:0]);
    assign hex1 = seg7(disp_bcd[7:4]);
    assign hex2 = seg7(disp_bcd[11:8]);
    assign hex3 = seg7(disp_bcd[15:12]);
    assign hex4 = seg7(disp_bcd[19:16]);
    assign hex5 = seg7(disp_bcd[23:20]);

endmodule

// File: tb/tb_stopwatch_lap.sv
// Scoreboard bench for stopwatch_lap: an integer-time reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_stopwatch_lap;

    localparam int TICK_DIV  = 4;
    localparam int DEBOUNCE  = 3;
    localparam int LAP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_start_pause = 1'b1;
    logic        key_lap = 1'b1;
    logic        key_recall = 1'b1;
    logic        mode_down = 1'b0;
    logic        preset_load = 1'b0;
    logic [23:0] preset_bcd = '0;
    logic [23:0] time_bcd;
    logic [23:0] disp_bcd;
    logic        running;
    logic        expired;
    logic [2:0]  lap_count;
    logic        lap_full;
    logic        recall_active;
    logic [1:0]  recall_idx;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int total = 0;
    int bad   = 0;

    stopwatch_lap #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE), .LAP_DEPTH(LAP_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .key_start_pause(key_start_pause), .key_lap(key_lap), .key_recall(key_recall),
        .mode_down(mode_down), .preset_load(preset_load), .preset_bcd(preset_bcd),
        .time_bcd(time_bcd), .disp_bcd(disp_bcd), .running(running), .expired(expired),
        .lap_count(lap_count), .lap_full(lap_full), .recall_active(recall_active),
        .recall_idx(recall_idx),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] tm;
        logic [23:0] disp;
        logic        run;
        logic        exp;
        logic [2:0]  cnt;
        logic        full;
        logic        ract;
        logic [1:0]  ridx;
        logic [41:0] hex;
    } snap_t;

    snap_t exp_q[$];

    // Reference model: time held as an integer count of hundredths.
    int          m_t, m_div, m_preset, m_ridx;
    bit          m_run, m_exp, m_tick, m_ract;
    logic [23:0] m_disp;
    logic [23:0] m_laps[$];
    bit          db_lvl[3], db_s1[3], db_s2[3];
    int          db_run[3];

    function automatic logic [23:0] to_bcd(input int t);
        int mm, ss, cc;
        mm = t / 6000;
        ss = (t / 100) % 60;
        cc = t % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] b);
        int mm, ss, cc;
        mm = int'(b[23:20]) * 10 + int'(b[19:16]);
        ss = int'(b[15:12]) * 10 + int'(b[11:8]);
        cc = int'(b[7:4]) * 10 + int'(b[3:0]);
        return mm * 6000 + ss * 100 + cc;
    endfunction

    function automatic bit bcd_ok(input logic [23:0] b);
        return b[23:20] <= 4'd5 && b[19:16] <= 4'd9 && b[15:12] <= 4'd5 &&
               b[11:8] <= 4'd9 && b[7:4] <= 4'd9 && b[3:0] <= 4'd9;
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d <= 4'd9) ? tbl[d] : 7'h7F;
    endfunction

    always @(posedge clk) begin
        bit          pr [3];
        bit          raw [3];
        bit          run0, ract0, load_ok, clr, tick_now;
        int          t0, cnt0, ridx0;
        logic [23:0] nd;
        snap_t       s;
        raw[0] = key_start_pause;
        raw[1] = key_lap;
        raw[2] = key_recall;
        for (int k = 0; k < 3; k++) pr[k] = 1'b0;
        if (reset) begin
            m_t = 0; m_div = 0; m_preset = 0; m_ridx = 0;
            m_run = 0; m_exp = 0; m_tick = 0; m_ract = 0;
            m_disp = '0;
            m_laps.delete();
            for (int k = 0; k < 3; k++) begin
                db_lvl[k] = 0; db_s1[k] = 0; db_s2[k] = 0; db_run[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (db_s2[k] == db_lvl[k]) begin
                    db_run[k] = 0;
                end else begin
                    db_run[k]++;
                    if (db_run[k] == DEBOUNCE) begin
                        db_lvl[k] = db_s2[k];
                        db_run[k] = 0;
                        pr[k]     = (db_s2[k] == 1'b0);
                    end
                end
                db_s2[k] = db_s1[k];
                db_s1[k] = raw[k];
            end
            run0  = m_run;
            t0    = m_t;
            cnt0  = m_laps.size();
            ract0 = m_ract;
            ridx0 = m_ridx;
            nd    = ract0 ? m_laps[ridx0] : to_bcd(t0);
            tick_now = m_tick;
            m_tick   = 0;
            if (run0) begin
                if (m_div == TICK_DIV - 1) begin
                    m_div  = 0;
                    m_tick = 1;
                end else begin
                    m_div++;
                end
            end
            if (tick_now) begin
                if (mode_down) begin
                    if (t0 <= 1) begin
                        m_t = 0; m_run = 0; m_exp = 1;
                    end else begin
                        m_t = t0 - 1;
                    end
                end else begin
                    m_t = (t0 + 1) % 360000;
                end
            end
            load_ok = preset_load && !run0 && bcd_ok(preset_bcd);
            clr     = pr[1] && !run0;
            if (load_ok) begin
                m_t = from_bcd(preset_bcd); m_preset = m_t; m_exp = 0;
            end else if (clr) begin
                m_t = mode_down ? m_preset : 0; m_div = 0;
            end
            if (pr[0]) begin
                m_exp = 0;
                if (run0) m_run = 0;
                else if (!(mode_down && t0 == 0)) m_run = 1;
            end
            if (pr[1]) begin
                if (run0) begin
                    if (cnt0 < LAP_DEPTH) m_laps.push_back(to_bcd(t0));
                end else begin
                    m_laps.delete();
                    m_ract = 0;
                end
            end
            if (pr[2] && cnt0 != 0 && !clr) begin
                if (!ract0) begin
                    m_ract = 1; m_ridx = 0;
                end else if (ridx0 == cnt0 - 1) begin
                    m_ract = 0;
                end else begin
                    m_ridx = ridx0 + 1;
                end
            end
            m_disp = nd;
        end
        s.tm   = to_bcd(m_t);
        s.disp = m_disp;
        s.run  = m_run;
        s.exp  = m_exp;
        s.cnt  = 3'(m_laps.size());
        s.full = (m_laps.size() == LAP_DEPTH);
        s.ract = m_ract;
        s.ridx = 2'(m_ridx);
        s.hex  = {seg(m_disp[23:20]), seg(m_disp[19:16]), seg(m_disp[15:12]),
                  seg(m_disp[11:8]), seg(m_disp[7:4]), seg(m_disp[3:0])};
        exp_q.push_back(s);
    end

    always @(negedge clk) begin
        snap_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {time_bcd, disp_bcd, running, expired, lap_count, lap_full, recall_active,
                 recall_idx, hex5, hex4, hex3, hex2, hex1, hex0};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL snapshot t=%0t: got time=%h disp=%h run=%b exp=%b cnt=%0d full=%b ract=%b idx=%0d hex=%h | want time=%h disp=%h run=%b exp=%b cnt=%0d full=%b ract=%b idx=%0d hex=%h",
                         $time, a.tm, a.disp, a.run, a.exp, a.cnt, a.full, a.ract, a.ridx, a.hex,
                         e.tm, e.disp, e.run, e.exp, e.cnt, e.full, e.ract, e.ridx, e.hex);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0:       key_start_pause = v;
            1:       key_lap = v;
            default: key_recall = v;
        endcase
    endtask

    task automatic press_key(input int k, input int hold);
        @(negedge clk);
        set_key(k, 1'b0);
        cycles(hold);
        set_key(k, 1'b1);
        cycles(DEBOUNCE + 6);
    endtask

    task automatic load(input logic [23:0] v);
        @(negedge clk);
        preset_bcd  = v;
        preset_load = 1'b1;
        @(negedge clk);
        preset_load = 1'b0;
        cycles(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cycles(DEBOUNCE + 6);
    endtask

    initial begin
        int op;
        int i;
        cycles(2);
        check("reset_time", 32'(time_bcd), 32'h0);
        check("reset_hex5", 32'(hex5), 32'h40);
        check("reset_run", 32'(running), 32'h0);
        reset = 1'b0;
        cycles(DEBOUNCE + 6);

        // Count up for about 100 ticks, then pause and hold.
        press_key(0, 6);
        cycles(100 * TICK_DIV);
        press_key(0, 6);
        check("paused", 32'(running), 32'h0);
        cycles(30);

        // Wrap 59:59.99 -> 00:00.00 while running.
        load(24'h595999);
        check("load_max", 32'(time_bcd), 32'h595999);
        @(negedge clk);
        set_key(0, 1'b0);
        i = 0;
        while (time_bcd == 24'h595999 && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("wrap_time", 32'(time_bcd), 32'h0);
        check("wrap_run", 32'(running), 32'h1);
        set_key(0, 1'b1);
        cycles(DEBOUNCE + 6);
        press_key(0, 6);

        // Count down to expiry; a further start press is ignored at zero.
        mode_down = 1'b1;
        load(24'h000003);
        @(negedge clk);
        set_key(0, 1'b0);
        i = 0;
        while (!expired && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("down_time", 32'(time_bcd), 32'h0);
        check("down_run", 32'(running), 32'h0);
        check("down_exp", 32'(expired), 32'h1);
        set_key(0, 1'b1);
        cycles(DEBOUNCE + 6);
        press_key(0, 6);
        check("start_at_zero", 32'(running), 32'h0);
        check("exp_cleared", 32'(expired), 32'h0);

        // Fill the lap buffer, drop the fifth, then step through recall.
        mode_down = 1'b0;
        press_key(1, 6);
        check("clear_time", 32'(time_bcd), 32'h0);
        press_key(0, 6);
        for (int n = 0; n < 5; n++) begin
            cycles($urandom_range(5, 40));
            press_key(1, 6);
        end
        check("lap_count", 32'(lap_count), 32'd4);
        check("lap_full", 32'(lap_full), 32'h1);
        for (int n = 0; n < 4; n++) begin
            press_key(2, 6);
            check("recall_act", 32'(recall_active), 32'h1);
            check("recall_idx", 32'(recall_idx), 32'(n));
            check("recall_disp", 32'(disp_bcd), 32'(m_laps[n]));
        end
        press_key(2, 6);
        check("recall_exit", 32'(recall_active), 32'h0);

        // Short glitch gives nothing; a long hold gives exactly one toggle.
        press_key(0, 2);
        check("glitch", 32'(running), 32'h1);
        press_key(0, 100);
        check("long_hold", 32'(running), 32'h0);
        load(24'h5A0000);
        check("bad_preset", 32'(time_bcd == 24'h5A0000), 32'h0);

        // Reset mid-run with laps and recall active.
        press_key(1, 6);
        press_key(0, 6);
        for (int n = 0; n < 3; n++) begin
            cycles($urandom_range(5, 20));
            press_key(1, 6);
        end
        press_key(2, 6);
        check("pre_reset_ract", 32'(recall_active), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_time", 32'(time_bcd), 32'h0);
        check("rst_disp", 32'(disp_bcd), 32'h0);
        check("rst_flags", 32'({running, expired, recall_active, lap_full}), 32'h0);
        check("rst_cnt", 32'(lap_count), 32'h0);
        check("rst_hex0", 32'(hex0), 32'h40);
        reset = 1'b0;
        cycles(DEBOUNCE + 6);

        // Randomised mix of key activity, mode changes, presets and resets.
        for (int n = 0; n < 90; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2: press_key(0, int'($urandom_range(1, 8)));
                3, 4:    press_key(1, int'($urandom_range(1, 8)));
                5, 6:    press_key(2, int'($urandom_range(1, 8)));
                7: begin
                    mode_down = 1'($urandom_range(0, 1));
                    cycles(2);
                end
                8: load({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                         4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
                default: begin
                    if ($urandom_range(0, 7) == 0) do_reset();
                    else cycles(int'($urandom_range(5, 60)));
                end
            endcase
        end
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
